// File: rtl/qpp_addr_seq.sv
// qpp_addr_seq: QPP interleaver address sequencer.
//
// Produces the interleaved address sequence pi(x) = (f1*x + f2*x^2) mod K for x = 0..K-1.
// It does this without multipliers, using the second-order recursion
//   pi(x+1)    = (pi(x) + gamma(x)) mod K,  pi(0)    = 0
//   gamma(x+1) = (gamma(x) + g) mod K,      gamma(0) = (f1 + f2) mod K,  g = 2*f2 mod K
// Each step is a single conditional subtraction (modadd), because every operand is already < K.
//
// Ports:
//   clk, rst      rising-edge clock; synchronous active-high reset
//   start         command strobe (only honoured in IDLE); latches k_len, f1, f2
//   k_len, f1, f2 block length K and QPP coefficients
//   abort         drop the current block and return to IDLE (no done pulse)
//   busy          high in every state except IDLE
//   addr_valid    address beat available; held until addr_ready
//   addr_ready    consumer accepts the beat
//   addr          pi(x)
//   addr_idx      x
//   addr_last     beat with x == K-1
//   done          one-cycle pulse after the final beat is accepted
//   err           parameter-error flag
//
// Build option QPP_PARAM_CHECK_EN: rejects starts with K == 0, f1 >= K, f2 >= K or an even f1.
// A rejected start sets err and leaves the FSM in IDLE. err clears on the next accepted start.
// Without the macro, err is tied to 0 and only K == 0 is rejected.

module qpp_addr_seq #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] k_len,
  input  logic [W-1:0] f1,
  input  logic [W-1:0] f2,
  input  logic         abort,
  output logic         busy,
  output logic         addr_valid,
  input  logic         addr_ready,
  output logic [W-1:0] addr,
  output logic [W-1:0] addr_idx,
  output logic         addr_last,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StDone
  } state_e;

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  // (a + b) mod k, valid when a < k and b < k. The sum is formed in W+1 bits so it cannot wrap.
  function automatic logic [W-1:0] modadd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] k);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) begin
      s = s - {1'b0, k};
    end
    return s[W-1:0];
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] f1_q, f1_d;
  logic [W-1:0] f2_q, f2_d;
  logic [W-1:0] pi_q, pi_d;
  logic [W-1:0] gamma_q, gamma_d;
  logic [W-1:0] g_q, g_d;
  logic [W-1:0] idx_q, idx_d;
  logic         start_ok;
  logic         is_last;

`ifdef QPP_PARAM_CHECK_EN
  logic err_q, err_d;

  assign start_ok = (k_len != '0) && (f1 < k_len) && (f2 < k_len) && f1[0];
  assign err      = err_q;
`else
  assign start_ok = (k_len != '0);
  assign err      = 1'b0;
`endif

  assign is_last = (idx_q == (k_q - One));

  // Moore outputs; addr/addr_idx come straight from the registers so they hold while stalled.
  assign busy       = (state_q != StIdle);
  assign addr_valid = (state_q == StRun);
  assign addr_last  = (state_q == StRun) && is_last;
  assign done       = (state_q == StDone);
  assign addr       = pi_q;
  assign addr_idx   = idx_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    pi_d    = pi_q;
    gamma_d = gamma_q;
    g_d     = g_q;
    idx_d   = idx_q;
`ifdef QPP_PARAM_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_ok) begin
            k_d     = k_len;
            f1_d    = f1;
            f2_d    = f2;
            state_d = StInit;
`ifdef QPP_PARAM_CHECK_EN
            err_d   = 1'b0;
`endif
          end else begin
`ifdef QPP_PARAM_CHECK_EN
            err_d   = 1'b1;
`endif
          end
        end
      end

      StInit: begin
        gamma_d = modadd(f1_q, f2_q, k_q);
        g_d     = modadd(f2_q, f2_q, k_q);
        pi_d    = '0;
        idx_d   = '0;
        state_d = StRun;
      end

      StRun: begin
        if (addr_ready) begin
          if (is_last) begin
            // Keep the final pi/idx visible; nothing further to advance.
            state_d = StDone;
          end else begin
            pi_d    = modadd(pi_q, gamma_q, k_q);
            gamma_d = modadd(gamma_q, g_q, k_q);
            idx_d   = idx_q + One;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // abort overrides everything outside IDLE, including a final handshake in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      pi_q    <= '0;
      gamma_q <= '0;
      g_q     <= '0;
      idx_q   <= '0;
`ifdef QPP_PARAM_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      pi_q    <= pi_d;
      gamma_q <= gamma_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
`ifdef QPP_PARAM_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_qpp_addr_seq.sv
// Scoreboard bench for qpp_addr_seq. Expected beats come from the closed form
// pi(x) = (f1*x + f2*x^2) mod K and are queued when a block is started. A separate monitor
// samples on the falling edge, pops one entry per handshake, and checks holds and done pulses.
module tb_qpp_addr_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, abort, addr_ready;
  logic [W-1:0] k_len, f1, f2;
  logic         busy, addr_valid, addr_last, done, err;
  logic [W-1:0] addr, addr_idx;

  always #5 clk = ~clk;

  qpp_addr_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .f1        (f1),
    .f2        (f2),
    .abort     (abort),
    .busy      (busy),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr      (addr),
    .addr_idx  (addr_idx),
    .addr_last (addr_last),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    longint addr;
    longint idx;
    bit     last;
  } beat_t;

  beat_t  exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     rand_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit params_ok(input int k, input int a, input int b);
`ifdef QPP_PARAM_CHECK_EN
    return (k != 0) && (a < k) && (b < k) && (a % 2 == 1);
`else
    return (k != 0);
`endif
  endfunction

  // ---------------- monitor ----------------
  bit           exp_done = 0;
  bit           stall    = 0;
  logic [W-1:0] s_addr, s_idx;

  always @(negedge clk) begin
    if (rst) begin
      stall    = 0;
      exp_done = 0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", done, 1);
        chk("valid_low_in_done", addr_valid, 0);
        exp_done = 0;
      end else if (done) begin
        chk("unexpected_done", done, 0);
      end
      if (stall) begin
        chk("hold_valid", addr_valid, 1);
        chk("hold_addr", addr, s_addr);
        chk("hold_idx", addr_idx, s_idx);
      end
      stall = 0;
      if (addr_valid) begin
        if (addr_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got idx %0d addr %0d, expected no beat", addr_idx,
                     addr);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_addr", addr, e.addr);
            chk("beat_idx", addr_idx, e.idx);
            chk("beat_last", addr_last, e.last);
            if (e.last) exp_done = 1;
          end
        end else begin
          stall  = 1;
          s_addr = addr;
          s_idx  = addr_idx;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) addr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_blk(input int k, input int a, input int b);
    bit ok;
    ok = params_ok(k, a, b);
    if (ok) begin
      for (int x = 0; x < k; x++) begin
        beat_t e;
        e.addr = (longint'(a) * x + longint'(b) * x * x) % k;
        e.idx  = x;
        e.last = (x == k - 1);
        exp_q.push_back(e);
      end
    end
    start = 1'b1;
    k_len = W'(k);
    f1    = W'(a);
    f2    = W'(b);
    tick();
    start = 1'b0;
`ifdef QPP_PARAM_CHECK_EN
    chk("err_after_start", err, ok ? 0 : 1);
`else
    chk("err_after_start", err, 0);
`endif
    chk("busy_after_start", busy, ok ? 1 : 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: busy=%0d pending=%0d after %0d cycles", name, busy,
               exp_q.size(), n);
      exp_q.delete();
    end
    tick();
    chk({"queue_empty_", name}, exp_q.size(), 0);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(addr_valid && addr_idx == W'(idx)) && n < 200) begin
      tick();
      n++;
    end
    chk("reached_idx", addr_idx, idx);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    k_len = '0; f1 = '0; f2 = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_last", addr_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_idx", addr_idx, 0);
    rst = 1'b0;
    tick();

    // LTE K=40 with ready held high, plus first-beat latency.
    start_blk(40, 3, 10);
    chk("init_valid_low", addr_valid, 0);
    tick();
    chk("first_valid", addr_valid, 1);
    chk("first_addr", addr, 0);
    wait_idle("k40", 200);

    // Same block with random backpressure.
    rand_mode = 1;
    start_blk(40, 3, 10);
    wait_idle("k40_bp", 2000);
    rand_mode = 0;
    addr_ready = 1'b1;

    // K=1; a second start while busy must be ignored.
    start_blk(1, 1, 0);
    if (busy) begin
      start = 1'b1; k_len = 16'd40; f1 = 16'd3; f2 = 16'd10;
      tick();
      start = 1'b0;
    end
    wait_idle("k1", 50);
    repeat (3) tick();
    chk("no_restart_busy", busy, 0);

    // Abort at idx 5, then a clean restart.
    start_blk(40, 3, 10);
    wait_idx(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", addr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_done2", done, 0);
    start_blk(40, 3, 10);
    wait_idle("after_abort", 200);

    // Reset mid-run, then a K=0 start.
    start_blk(40, 3, 10);
    wait_idx(7);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", addr_valid, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_idx", addr_idx, 0);
    chk("midrst_last", addr_last, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    tick();
    start = 1'b1; k_len = '0; f1 = 16'd3; f2 = 16'd10;
    tick();
    start = 1'b0;
    chk("k0_busy", busy, 0);
`ifdef QPP_PARAM_CHECK_EN
    chk("k0_err", err, 1);
`else
    chk("k0_err", err, 0);
`endif
    tick();
    chk("k0_busy2", busy, 0);
    chk("k0_valid", addr_valid, 0);

    // Even f1: rejected with the check enabled, otherwise runs normally.
    start_blk(40, 4, 10);
    wait_idle("even_f1", 200);
    start_blk(40, 3, 10);
    wait_idle("valid_after_even", 200);

    // Random blocks with random backpressure.
    rand_mode = 1;
    for (int t = 0; t < 6; t++) begin
      int k, a, b;
      k = $urandom_range(1, 48);
      a = $urandom % k;
      if (a % 2 == 0) a = a + 1;
      if (a >= k) a = (k >= 2) ? 1 : 0;
      b = $urandom % k;
      start_blk(k, a, b);
      wait_idle("random", 1000);
    end
    rand_mode = 0;
    addr_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qpp_addr_seq.md
Name: qpp_addr_seq

Overview:
- Sequencer for the QPP interleaver recursion: pi(x+1) = (pi(x) + gamma(x)) mod K and gamma(x+1) = (gamma(x) + g) mod K, where g = 2*f2.
- Accepts a block command (K, f1, f2), derives gamma(0) and g, then streams K interleaved addresses pi(0..K-1) to the memory/decoder side over a valid/ready handshake.
- Sits between the turbo block controller and the interleaved-address consumer.

Parameters:
- W, 16, width of K, f1, f2 and all address/index datapaths.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- k_len  in  W  block length K; latched on start.
- f1  in  W  QPP coefficient f1; latched on start.
- f2  in  W  QPP coefficient f2; latched on start.
- abort  in  1  synchronous abort of the current block.
- busy  out  1  high in every state except IDLE.
- addr_valid  out  1  pi address available.
- addr_ready  in  1  consumer accepts the address.
- addr  out  W  current pi(x).
- addr_idx  out  W  current x.
- addr_last  out  1  high with addr_valid when x == K-1.
- done  out  1  single-cycle pulse after the final address is accepted.
- err  out  1  parameter-error flag (see Optional Feature; tied 0 without it).

Behaviour:
- Reset: state=IDLE; busy, addr_valid, addr_last, done, err = 0; addr, addr_idx and internal pi, gamma, g, K = 0. Reset mid-block discards the block immediately.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE:
  - start=1 latches k_len, f1, f2 and moves to INIT.
  - start=1 with k_len == 0 is ignored; the FSM stays in IDLE.
- INIT (exactly 1 cycle):
  - gamma <= modadd(f1, f2); g <= modadd(f2, f2); pi <= 0; idx <= 0.
  - Next state is RUN.
- RUN:
  - addr_valid=1, addr=pi, addr_idx=idx, addr_last=(idx == K-1).
  - On addr_valid && addr_ready: pi <= modadd(pi, gamma); gamma <= modadd(gamma, g); idx <= idx+1.
  - If addr_last is high on the handshake, go to DONE instead of advancing.
  - With addr_ready low, all outputs hold stable. valid must not drop until the handshake completes.
- DONE (1 cycle): done=1, busy=1, addr_valid=0. Next state is IDLE.
- First address pi(0)=0 appears 2 cycles after the start cycle. Steady-state throughput is 1 address/cycle with ready held high.
- modadd(a,b): s = a+b in W+1 bits; result = (s >= K) ? s-K : s. Operands must be < K; this holds by construction for pi, gamma and g. f1, f2 >= K gives unspecified addresses unless the check below is enabled.
- K=1: INIT, then one RUN beat with addr=0 and addr_last=1, then DONE.
- abort:
  - In INIT, RUN or DONE, go to IDLE next cycle. addr_valid drops next cycle; no done pulse.
  - Abort on the same cycle as the last handshake: abort wins, no done.
  - Ignored in IDLE.
- start while busy is ignored. rst has priority over abort and start.

Optional Feature:
- Macro: QPP_PARAM_CHECK_EN.
- Defined:
  - On start in IDLE, if k_len==0, f1>=k_len, f2>=k_len, or f1 is even, set err=1 and stay in IDLE. No block runs.
  - err clears on the next accepted (valid) start or on rst.
- Undefined: no checks are made. err is constant 0, and a start with k_len==0 is still ignored.

Test Plan:
- LTE K=40, f1=3, f2=10, ready held 1 -> addr sequence 0, 13, 6, 19, 12, ... for 40 beats matching (3x+10x²) mod 40; addr_last only on idx 39; done pulse 1 cycle after beat 39; first valid 2 cycles after start.
- Same block with addr_ready toggled pseudo-randomly -> addr/addr_idx held stable while ready=0; identical 40-address sequence; no beat lost or duplicated.
- K=1, f1=1, f2=0 -> exactly one beat, addr=0, addr_last=1, then done; start during busy ignored.
- abort asserted at idx=5 of the K=40 block -> addr_valid low next cycle, busy low, no done; new start then produces 0, 13, 6, ... from idx 0.
- rst asserted mid-RUN -> all outputs 0 next cycle; a start with k_len=0 -> FSM stays IDLE, busy=0.
- With QPP_PARAM_CHECK_EN: K=40, f1=4, f2=10 -> err=1, no addr_valid; a following valid start clears err and runs normally.
